ka_seq_ctrl_64bit: RTL

KA_SEQ_CTRL_64BIT -- requirements
Module: ka_seq_ctrl_64bit

---
 rtl/ka_seq_ctrl_64bit_if.sv | 23 ++
 rtl/ka_seq_ctrl_64bit.sv | 109 ++++++++++
 2 files changed

// File: rtl/ka_seq_ctrl_64bit_if.sv
// Operand-in / product-out handshake bundle for the Karatsuba carry-less multiply sequencer.
// The master side is the producer of operands and consumer of products.
interface ka_seq_ctrl_64bit_if #(
    parameter int n = 64
);
    logic           in_valid;
    logic           in_ready;
    logic [n-1:0]   a;
    logic [n-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*n-2:0] out_p;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out_p
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out_p
    );
endinterface

// File: rtl/ka_seq_ctrl_64bit.sv
// Sequences one 64x64 GF(2) product through a shared 32x32 carry-less multiplier
// using three Karatsuba partial products (lo, hi, middle) over three cycles.
module ka_seq_ctrl_64bit #(
    parameter int n = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ka_seq_ctrl_64bit_if.slave   bus,
    output logic [n/2-1:0]       mul_a,
    output logic [n/2-1:0]       mul_b,
    input  logic [n-2:0]         mul_p,
    output logic                 busy
);
    localparam int h = n / 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL_LO  = 3'd1,
        MUL_HI  = 3'd2,
        MUL_MID = 3'd3,
        OUT     = 3'd4
    } state_t;

    state_t         state_reg;
    state_t         state_next;
    logic [n-1:0]   a_reg;
    logic [n-1:0]   b_reg;
    logic [n-2:0]   p0_reg;
    logic [n-2:0]   p2_reg;
    logic [2*n-2:0] out_p_reg;
    logic [2*n-2:0] out_p_next;
    logic [n-2:0]   m_comb;
    logic [h-1:0]   mul_a_sel;
    logic [h-1:0]   mul_b_sel;

    // Middle Karatsuba term only meaningful while MUL_MID drives the multiplier.
    assign m_comb     = mul_p ^ p0_reg ^ p2_reg;
    assign out_p_next = {{n{1'b0}}, p0_reg}
                      ^ {{h{1'b0}}, m_comb, {h{1'b0}}}
                      ^ {p2_reg, {n{1'b0}}};

    always_comb begin
        state_next = state_reg;
        mul_a_sel  = '0;
        mul_b_sel  = '0;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    state_next = MUL_LO;
                end
            end
            MUL_LO: begin
                mul_a_sel  = a_reg[h-1:0];
                mul_b_sel  = b_reg[h-1:0];
                state_next = MUL_HI;
            end
            MUL_HI: begin
                mul_a_sel  = a_reg[n-1:h];
                mul_b_sel  = b_reg[n-1:h];
                state_next = MUL_MID;
            end
            MUL_MID: begin
                mul_a_sel  = a_reg[h-1:0] ^ a_reg[n-1:h];
                mul_b_sel  = b_reg[h-1:0] ^ b_reg[n-1:h];
                state_next = OUT;
            end
            OUT: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Multiplier operands are forced quiet while reset is held, not just after its edge.
    assign mul_a = rst_n ? mul_a_sel : '0;
    assign mul_b = rst_n ? mul_b_sel : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            p0_reg    <= '0;
            p2_reg    <= '0;
            out_p_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg <= bus.a;
                        b_reg <= bus.b;
                    end
                end
                MUL_LO:  p0_reg    <= mul_p;
                MUL_HI:  p2_reg    <= mul_p;
                MUL_MID: out_p_reg <= out_p_next;
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = rst_n && (state_reg == IDLE);
    assign bus.out_valid = (state_reg == OUT);
    assign bus.out_p     = out_p_reg;
    assign busy          = (state_reg != IDLE);
endmodule
